// File: rtl/alt_vipitc130_seq_pkg.sv
// alt_vipitc130 timing sequencer: shared types and helpers.
// Provides the sequencer state encoding and the line-length helper.
package alt_vipitc130_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } seq_state_t;

  // LINE_TOTAL helper: samples per full line (active + blank).
  function automatic int line_total(
    input int h_active,
    input int h_blank
  );
    return h_active + h_blank;
  endfunction

endpackage

// File: rtl/alt_vipitc130_common_sample_counter.sv
// alt_vipitc130 colour-plane phase counter.
// Ports: clk, rst (async, high), sclr, count_cycle, hd_sdn (latched mode)
//   -> count_sample (last plane of a sample), start_of_sample (first plane),
//      sample_ticks (current plane index).
module alt_vipitc130_common_sample_counter #(
  parameter int NUMBER_OF_COLOUR_PLANES      = 3,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  input  logic count_cycle,
  input  logic hd_sdn,
  output logic count_sample,
  output logic start_of_sample,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks
);

  localparam int TW = LOG2_NUMBER_OF_COLOUR_PLANES;
  localparam logic [TW-1:0] LAST_TICK =
    TW'(NUMBER_OF_COLOUR_PLANES - 1);

  logic at_last;

  // In parallel mode every cycle carries a whole sample.
  assign at_last = hd_sdn | (sample_ticks == LAST_TICK);
  assign count_sample = count_cycle & at_last;
  assign start_of_sample = hd_sdn | (sample_ticks == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_ticks <= '0;
    end else if (sclr) begin
      sample_ticks <= '0;
    end else if (count_cycle && !hd_sdn) begin
      if (sample_ticks == LAST_TICK)
        sample_ticks <= '0;
      else
        sample_ticks <= sample_ticks + 1'b1;
    end
  end

endmodule

// File: rtl/alt_vipitc130_common_timing_sequencer.sv
// alt_vipitc130 frame/line timing sequencer (IDLE/ACTIVE/HBLANK/VBLANK).
// Ports: clk, rst (async, high), sclr, enable, go, hd_sdn, pixel_valid
//   -> count_cycle, active, plane_index, sof, eol, h_count, v_count,
//      underflow.
// Option: define ALT_VIPITC130_SEQ_UNDERFLOW_EN for the sticky underflow
// flag; otherwise underflow is tied low and pixel_valid is ignored.
module alt_vipitc130_common_timing_sequencer
  import alt_vipitc130_seq_pkg::*;
#(
  parameter int NUMBER_OF_COLOUR_PLANES      = 3,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
  parameter int H_WIDTH                      = 12,
  parameter int V_WIDTH                      = 12,
  parameter int H_ACTIVE                     = 1920,
  parameter int H_BLANK                      = 280,
  parameter int V_ACTIVE                     = 1080,
  parameter int V_BLANK                      = 45
) (
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  input  logic enable,
  input  logic go,
  input  logic hd_sdn,
  input  logic pixel_valid,
  output logic count_cycle,
  output logic active,
  output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_index,
  output logic sof,
  output logic eol,
  output logic [H_WIDTH-1:0] h_count,
  output logic [V_WIDTH-1:0] v_count,
  output logic underflow
);

  localparam int LINE_TOTAL = line_total(H_ACTIVE, H_BLANK);
  localparam logic [H_WIDTH-1:0] H_ACT_LAST =
    H_WIDTH'(H_ACTIVE - 1);
  localparam logic [H_WIDTH-1:0] H_BLK_LAST =
    H_WIDTH'(H_BLANK - 1);
  localparam logic [H_WIDTH-1:0] H_LINE_LAST =
    H_WIDTH'(LINE_TOTAL - 1);
  localparam logic [V_WIDTH-1:0] V_ACT_LAST =
    V_WIDTH'(V_ACTIVE - 1);
  localparam logic [V_WIDTH-1:0] V_BLK_LAST =
    (V_BLANK > 0) ? V_WIDTH'(V_BLANK - 1) : '0;
  localparam bit HAS_VBLANK = (V_BLANK > 0);

  seq_state_t state;
  seq_state_t restart_state;
  logic       hd_sdn_latched;
  logic       sample_done;
  logic       start_of_sample;
  logic       phase_clr;

  assign count_cycle = enable & (state != IDLE);
  assign active = (state == ACTIVE);
  assign restart_state = go ? ACTIVE : IDLE;

  // Plane phase restarts whenever the sequencer is idle.
  assign phase_clr = sclr | (state == IDLE);

  alt_vipitc130_common_sample_counter #(
    .NUMBER_OF_COLOUR_PLANES     (NUMBER_OF_COLOUR_PLANES),
    .LOG2_NUMBER_OF_COLOUR_PLANES(LOG2_NUMBER_OF_COLOUR_PLANES)
  ) u_sample_counter (
    .clk            (clk),
    .rst            (rst),
    .sclr           (phase_clr),
    .count_cycle    (count_cycle),
    .hd_sdn         (hd_sdn_latched),
    .count_sample   (sample_done),
    .start_of_sample(start_of_sample),
    .sample_ticks   (plane_index)
  );

  assign sof = count_cycle & active & (h_count == '0) &
               (v_count == '0) & start_of_sample;
  assign eol = active & (h_count == H_ACT_LAST) & sample_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      h_count        <= '0;
      v_count        <= '0;
      hd_sdn_latched <= 1'b0;
    end else if (sclr) begin
      state   <= IDLE;
      h_count <= '0;
      v_count <= '0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state          <= ACTIVE;
            h_count        <= '0;
            v_count        <= '0;
            hd_sdn_latched <= hd_sdn;
          end
        end
        ACTIVE: begin
          if (sample_done) begin
            if (h_count == H_ACT_LAST) begin
              state   <= HBLANK;
              h_count <= '0;
            end else begin
              h_count <= h_count + 1'b1;
            end
          end
        end
        HBLANK: begin
          if (sample_done) begin
            if (h_count == H_BLK_LAST) begin
              h_count <= '0;
              if (v_count < V_ACT_LAST) begin
                state   <= ACTIVE;
                v_count <= v_count + 1'b1;
              end else if (HAS_VBLANK) begin
                state   <= VBLANK;
                v_count <= '0;
              end else begin
                state   <= restart_state;
                v_count <= '0;
              end
            end else begin
              h_count <= h_count + 1'b1;
            end
          end
        end
        VBLANK: begin
          if (sample_done) begin
            if (h_count == H_LINE_LAST) begin
              h_count <= '0;
              if (v_count == V_BLK_LAST) begin
                state   <= restart_state;
                v_count <= '0;
              end else begin
                v_count <= v_count + 1'b1;
              end
            end else begin
              h_count <= h_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALT_VIPITC130_SEQ_UNDERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underflow <= 1'b0;
    else if (sclr)
      underflow <= 1'b0;
    else if (active && count_cycle && !pixel_valid)
      underflow <= 1'b1;
  end
`else
  logic unused_pixel_valid;
  assign unused_pixel_valid = pixel_valid;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc130_common_timing_sequencer.sv
// Bench for alt_vipitc130_common_timing_sequencer.
// Expected per-cycle outputs come from frame-position arithmetic.
module tb_alt_vipitc130_common_timing_sequencer;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 2;
  localparam int VB = 1;
  localparam int NP = 3;
`ifdef ALT_VIPITC130_SEQ_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  typedef struct packed {
    logic        cc;
    logic        act;
    logic [1:0]  pi;
    logic        sof;
    logic        eol;
    logic [11:0] h;
    logic [11:0] v;
    logic        uf;
  } exp_t;

  logic clk, rst, sclr, enable, go, hd_sdn, pixel_valid;
  logic count_cycle, active, sof, eol, underflow;
  logic [1:0] plane_index;
  logic [11:0] h_count, v_count;
  logic n_count_cycle, n_active, n_sof, n_eol, n_underflow;
  logic [1:0] n_plane_index;
  logic [11:0] n_h_count, n_v_count;

  int total = 0;
  int bad = 0;
  string phase = "init";
  exp_t sb[$];

  alt_vipitc130_common_timing_sequencer #(
    .NUMBER_OF_COLOUR_PLANES(NP), .LOG2_NUMBER_OF_COLOUR_PLANES(2),
    .H_WIDTH(12), .V_WIDTH(12),
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .enable(enable), .go(go),
    .hd_sdn(hd_sdn), .pixel_valid(pixel_valid),
    .count_cycle(count_cycle), .active(active),
    .plane_index(plane_index), .sof(sof), .eol(eol),
    .h_count(h_count), .v_count(v_count), .underflow(underflow)
  );

  alt_vipitc130_common_timing_sequencer #(
    .NUMBER_OF_COLOUR_PLANES(NP), .LOG2_NUMBER_OF_COLOUR_PLANES(2),
    .H_WIDTH(12), .V_WIDTH(12),
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(0)
  ) dut_nvb (
    .clk(clk), .rst(rst), .sclr(sclr), .enable(enable), .go(go),
    .hd_sdn(hd_sdn), .pixel_valid(pixel_valid),
    .count_cycle(n_count_cycle), .active(n_active),
    .plane_index(n_plane_index), .sof(n_sof), .eol(n_eol),
    .h_count(n_h_count), .v_count(n_v_count),
    .underflow(n_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h",
             phase, tag, obs, exp);
    end
  endtask

  // Expected outputs at enabled cycle c of a frame, k cycles/sample.
  function automatic exp_t exp_at(input int c, input int k);
    exp_t e;
    int lp, ln, pos;
    lp = (HA + HB) * k;
    ln = c / lp;
    pos = c % lp;
    e = '0;
    e.cc = 1'b1;
    e.pi = 2'(pos % k);
    if (ln < VA) begin
      e.v = 12'(ln);
      if (pos < HA * k) begin
        e.act = 1'b1;
        e.h = 12'(pos / k);
        e.eol = (pos == HA * k - 1);
        e.sof = (c == 0);
      end else begin
        e.h = 12'((pos - HA * k) / k);
      end
    end else begin
      e.h = 12'(pos / k);
    end
    return e;
  endfunction

  task automatic cyc(input exp_t e);
    exp_t x;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    chk("count_cycle", 32'(count_cycle), 32'(x.cc));
    chk("active", 32'(active), 32'(x.act));
    chk("plane_index", 32'(plane_index), 32'(x.pi));
    chk("sof", 32'(sof), 32'(x.sof));
    chk("eol", 32'(eol), 32'(x.eol));
    chk("h_count", 32'(h_count), 32'(x.h));
    chk("v_count", 32'(v_count), 32'(x.v));
    chk("underflow", 32'(underflow), 32'(x.uf));
    @(negedge clk);
  endtask

  initial begin
    exp_t idle_e, x;
    idle_e = '0;
    rst = 1'b1; sclr = 1'b0; enable = 1'b0; go = 1'b0;
    hd_sdn = 1'b0; pixel_valid = 1'b1;
    repeat (2) @(negedge clk);

    phase = "reset";
    cyc(idle_e);
    rst = 1'b0;
    enable = 1'b1;

    phase = "serial";
    go = 1'b1;
    cyc(idle_e);
    for (int c = 0; c < 54; c++) cyc(exp_at(c, NP));
    phase = "go_drop";
    for (int c = 0; c < 54; c++) begin
      if (c == 10) go = 1'b0;
      cyc(exp_at(c, NP));
    end
    repeat (3) cyc(idle_e);

    phase = "parallel";
    hd_sdn = 1'b1;
    go = 1'b1;
    cyc(idle_e);
    for (int t = 0; t < 36; t++) begin
      if (t == 21) hd_sdn = 1'b0;
      if (t == 23) go = 1'b0;
      #1;
      chk("nvb_active", 32'(n_active),
          32'((t < 24) && ((t % 6) < HA)));
      chk("nvb_sof", 32'(n_sof),
          32'((t < 24) && ((t % 12) == 0)));
      cyc(exp_at(t % 18, 1));
    end
    repeat (2) cyc(idle_e);

    phase = "enable";
    hd_sdn = 1'b0;
    go = 1'b1;
    cyc(idle_e);
    for (int e = 0; e < 54; e++) begin
      if (e == 20) go = 1'b0;
      enable = 1'b0;
      x = exp_at(e, NP);
      x.cc = 1'b0; x.sof = 1'b0; x.eol = 1'b0;
      cyc(x);
      enable = 1'b1;
      cyc(exp_at(e, NP));
    end
    cyc(idle_e);

    phase = "sclr";
    hd_sdn = 1'b1;
    go = 1'b1;
    cyc(idle_e);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) sclr = 1'b1;
      cyc(exp_at(c, 1));
    end
    sclr = 1'b0;
    cyc(idle_e);
    for (int c = 0; c < 8; c++) cyc(exp_at(c, 1));

    phase = "rst";
    rst = 1'b1;
    cyc(idle_e);
    rst = 1'b0;
    go = 1'b0;
    cyc(idle_e);

    phase = "underflow";
    go = 1'b1;
    cyc(idle_e);
    for (int c = 0; c < 9; c++) begin
      pixel_valid = (c != 0);
      x = exp_at(c, 1);
      x.uf = UF_EN && (c >= 1);
      cyc(x);
    end
    sclr = 1'b1;
    x = exp_at(9, 1);
    x.uf = UF_EN;
    cyc(x);
    sclr = 1'b0;
    go = 1'b0;
    cyc(idle_e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alt_vipitc130_common_timing_sequencer.md
# alt_vipitc130_common_timing_sequencer

Frame/line timing sequencer for the clocked-video output path. It generates the per-cycle `count_cycle` strobe and walks a state machine through active samples, horizontal blanking and vertical blanking. Colour-plane phase is tracked by an internal sample-tick counter, so the block supports both serial (one plane per cycle) and parallel (one sample per cycle) transmission. It drives the output formatter's plane select, active-video and start-of-frame/end-of-line markers.

## Interface
- NUMBER_OF_COLOUR_PLANES, 3: planes per sample.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: plane-index width (≥1).
- H_WIDTH, 12: width of the horizontal counter.
- V_WIDTH, 12: width of the vertical counter.
- H_ACTIVE, 1920: active samples per line (≥1).
- H_BLANK, 280: blank samples per line (≥1).
- V_ACTIVE, 1080: active lines per frame (≥1).
- V_BLANK, 45: blank lines per frame (0 allowed; VBLANK state is then skipped).
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- sclr  in  1  synchronous clear; forces IDLE.
- enable  in  1  clock enable; low freezes all state.
- go  in  1  level; start/continue frames.
- hd_sdn  in  1  1 = planes in parallel (1 cycle/sample); 0 = serial.
- pixel_valid  in  1  upstream has the current sample.
- count_cycle  out  1  enable and state≠IDLE.
- active  out  1  state==ACTIVE.
- plane_index  out  LOG2_NUMBER_OF_COLOUR_PLANES  current plane (0 when hd_sdn=1).
- sof  out  1  first cycle of frame.
- eol  out  1  last cycle of active line.
- h_count  out  H_WIDTH  sample index within current state.
- v_count  out  V_WIDTH  line index within ACTIVE or VBLANK.
- underflow  out  1  sticky underflow flag.

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- sample_done = count_sample from the sub-module.
  - hd_sdn=1: sample_done = count_cycle.
  - hd_sdn=0: sample_done is count_cycle on the last plane.
- IDLE:
  - With enable & go, go to ACTIVE with h_count=0, v_count=0.
  - Otherwise stay.
- ACTIVE:
  - h_count increments on sample_done.
  - At h_count==H_ACTIVE-1 & sample_done: go to HBLANK, h_count←0.
- HBLANK:
  - At h_count==H_BLANK-1 & sample_done, h_count←0, then:
    - if v_count<V_ACTIVE-1: go to ACTIVE, v_count+1;
    - else if V_BLANK>0: go to VBLANK, v_count←0;
    - else frame end.
- VBLANK:
  - h_count counts H_ACTIVE+H_BLANK samples per line.
  - At end of each line: h_count←0, v_count+1.
  - After line V_BLANK-1: frame end.
- Frame end: go=1 → ACTIVE (new frame, counters 0); go=0 → IDLE. go is sampled only at frame end and in IDLE.
- sof = active & h_count==0 & v_count==0 & start_of_sample.
- eol = active & h_count==H_ACTIVE-1 & sample_done.
- sclr (any state) → IDLE, counters 0, plane phase 0, underflow cleared. sclr has priority over enable.

## Timing
- Reset values: state IDLE. All outputs 0: count_cycle, active, plane_index, sof, eol, h_count, v_count, underflow.
- Registered state and counters; outputs decode combinationally from registers and enable.
- go asserted with enable at edge N → active=1 and sof=1 in cycle N+1.
- Line period: (H_ACTIVE+H_BLANK)·k enabled cycles.
  - k=1 when hd_sdn=1.
  - k=NUMBER_OF_COLOUR_PLANES when hd_sdn=0.
- enable low: no state, counter or phase change; count_cycle=0; sof/eol=0.
- hd_sdn changes are honoured only in IDLE; the value is latched on leaving IDLE.
- rst mid-frame: immediate IDLE; no partial line is completed.

## Configuration
- ALT_VIPITC130_SEQ_UNDERFLOW_EN defined:
  - underflow sets when active & count_cycle & !pixel_valid.
  - Cleared only by rst or sclr.
- Not defined: underflow tied 0; pixel_valid ignored.

## Structure
- Shared package alt_vipitc130_seq_pkg:
  - state enum (IDLE=0, ACTIVE=1, HBLANK=2, VBLANK=3);
  - helper constant LINE_TOTAL = H_ACTIVE+H_BLANK.
- One sub-module instance: alt_vipitc130_common_sample_counter.
  - Inputs: count_cycle, hd_sdn_latched; sclr = sclr | state==IDLE.
  - Outputs used: count_sample, start_of_sample, sample_ticks (drives plane_index).
  - Contract: plane counter 0..NUMBER_OF_COLOUR_PLANES-1 that wraps on count_cycle.

## Test plan
- Parameters for the bench: planes=3, H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=1.
- Serial, go held, enable=1:
  - sof one cycle after go;
  - active for 12 cycles, then 6 cycles low, per line;
  - frame = 54 cycles;
  - plane_index cycles 0,1,2.
- hd_sdn=1: line = 6 cycles, frame = 18 cycles, plane_index stays 0, eol on the 4th active cycle.
- go dropped mid-frame: the frame completes; IDLE after cycle 54; count_cycle=0.
- enable toggled every other cycle: all durations double; counters are held while enable=0.
- sclr asserted in HBLANK: next cycle IDLE, h_count=v_count=0. rst asserted in ACTIVE: immediate all-zero outputs.
- With ALT_VIPITC130_SEQ_UNDERFLOW_EN: pixel_valid=0 for one active cycle → underflow=1 next cycle, held until sclr. With V_BLANK=0 build: HBLANK goes straight to a new ACTIVE frame.
